fpd_link_rx_deframer: RTL and testbench

//  Receive-side counterpart of the LCD serial link: 1:7 deserializer and frame aligner for a
//  3-data-lane + 1-clock-lane FPD-Link (18-bit RGB666) stream. Lanes arrive as single-ended bits

---
 rtl/fpd_link_rx_deframer.sv | 200 ++++++++++++++++++++
 tb/tb_fpd_link_rx_deframer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpd_link_rx_deframer.sv
// FPD-Link receive deframer: 1:7 deserialiser for three data lanes plus a clock lane.
// Aligns to the clock-lane word, then emits one RGB666 pixel with syncs per 7-bit frame.
module fpd_link_rx_deframer #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter logic [6:0]  CLK_PATTERN  = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] lane_i,
    input  logic       clk_lane_i,
    output logic       pix_valid_o,
    output logic [5:0] red_o,
    output logic [5:0] green_o,
    output logic [5:0] blue_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic       locked_o,
    output logic       sym_err_o
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned EW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_MAX   = GW'(LOCK_COUNT);
    localparam logic [EW-1:0] UNLOCK_MAX = EW'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [GW-1:0] good_cnt_q;
    logic [EW-1:0] err_cnt_q;
    logic          locked_q;
    logic          pix_valid_q;
    logic          sym_err_q;
    logic [5:0]    red_q;
    logic [5:0]    green_q;
    logic [5:0]    blue_q;
    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;

    // Only six history bits are stored; the seventh bit of each word is the live input.
    logic [5:0]    clk_sr_q, lane0_sr_q, lane1_sr_q, lane2_sr_q;
    logic [5:0]    clk_sr_d, lane0_sr_d, lane1_sr_d, lane2_sr_d;
    logic [6:0]    clk_word_s, w0_s, w1_s, w2_s;
    logic          clk_match_s;
    logic          boundary_s;
    logic [GW-1:0] good_inc_s;
    logic [EW-1:0] err_inc_s;
    logic          emit_s;

    assign clk_word_s  = {clk_sr_q, clk_lane_i};
    assign w0_s        = {lane0_sr_q, lane_i[0]};
    assign w1_s        = {lane1_sr_q, lane_i[1]};
    assign w2_s        = {lane2_sr_q, lane_i[2]};
    assign clk_sr_d    = clk_word_s[5:0];
    assign lane0_sr_d  = w0_s[5:0];
    assign lane1_sr_d  = w1_s[5:0];
    assign lane2_sr_d  = w2_s[5:0];
    assign clk_match_s = (clk_word_s == CLK_PATTERN);
    assign boundary_s  = (bit_cnt_q == 3'd6);
    assign good_inc_s  = good_cnt_q + GW'(1);
    assign err_inc_s   = err_cnt_q + EW'(1);

    // Pixel is emitted at a locked boundary unless this mismatch is the one that drops lock.
    always_comb begin
        emit_s = 1'b0;
        if ((state_q == ST_LOCKED) && boundary_s) begin
            if (clk_match_s) begin
                emit_s = 1'b1;
            end else if (err_inc_s != UNLOCK_MAX) begin
                emit_s = 1'b1;
            end else begin
                emit_s = 1'b0;
            end
        end else begin
            emit_s = 1'b0;
        end
    end

    // Serial-to-parallel history for all four lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr_q   <= 6'd0;
            lane0_sr_q <= 6'd0;
            lane1_sr_q <= 6'd0;
            lane2_sr_q <= 6'd0;
        end else begin
            clk_sr_q   <= clk_sr_d;
            lane0_sr_q <= lane0_sr_d;
            lane1_sr_q <= lane1_sr_d;
            lane2_sr_q <= lane2_sr_d;
        end
    end

    // Alignment FSM with bit counter, lock/unlock counters and status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            bit_cnt_q   <= 3'd0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            sym_err_q   <= 1'b0;
        end else begin
            pix_valid_q <= emit_s;
            sym_err_q   <= 1'b0;
            bit_cnt_q   <= boundary_s ? 3'd0 : bit_cnt_q + 3'd1;
            case (state_q)
                ST_SEARCH: begin
                    if (clk_match_s) begin
                        // Restart the counter so the next boundary lands one frame later.
                        bit_cnt_q  <= 3'd0;
                        good_cnt_q <= GW'(1);
                        if (LOCK_MAX == GW'(1)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (boundary_s) begin
                        if (clk_match_s) begin
                            good_cnt_q <= good_inc_s;
                            if (good_inc_s == LOCK_MAX) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            state_q    <= ST_SEARCH;
                            good_cnt_q <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary_s) begin
                        if (clk_match_s) begin
                            err_cnt_q <= '0;
                        end else begin
                            sym_err_q <= 1'b1;
                            if (err_inc_s == UNLOCK_MAX) begin
                                state_q    <= ST_SEARCH;
                                locked_q   <= 1'b0;
                                err_cnt_q  <= '0;
                                good_cnt_q <= '0;
                            end else begin
                                err_cnt_q <= err_inc_s;
                            end
                        end
                    end
                end
                default: begin
                    state_q    <= ST_SEARCH;
                    locked_q   <= 1'b0;
                    good_cnt_q <= '0;
                    err_cnt_q  <= '0;
                end
            endcase
        end
    end

    // Pixel and sync registers load from the word map and hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= 6'd0;
            green_q <= 6'd0;
            blue_q  <= 6'd0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else if (emit_s) begin
            red_q   <= w0_s[5:0];
            green_q <= {w1_s[4:0], w0_s[6]};
            blue_q  <= {w2_s[3:0], w1_s[6:5]};
            hsync_q <= w2_s[4];
            vsync_q <= w2_s[5];
            de_q    <= w2_s[6];
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign sym_err_o   = sym_err_q;
    assign locked_o    = locked_q;
    assign red_o       = red_q;
    assign green_o     = green_q;
    assign blue_o      = blue_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign de_o        = de_q;

endmodule

// File: tb/tb_fpd_link_rx_deframer.sv
// Bench for fpd_link_rx_deframer: directed stream scenarios with random pixel data,
// checked every cycle against a bit-stream reference model plus a transmitted-pixel scoreboard.
module tb_fpd_link_rx_deframer;

    localparam int         LOCK   = 4;
    localparam int         UNLOCK = 3;
    localparam logic [6:0] PAT    = 7'b1100011;
    localparam logic [6:0] GLITCH = 7'b1100001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] lane = 3'd0;
    logic       clk_lane = 1'b0;
    logic       pix_valid_o, hsync_o, vsync_o, de_o, locked_o, sym_err_o;
    logic [5:0] red_o, green_o, blue_o;

    fpd_link_rx_deframer #(
        .LOCK_COUNT  (LOCK),
        .UNLOCK_COUNT(UNLOCK),
        .CLK_PATTERN (PAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lane_i     (lane),
        .clk_lane_i (clk_lane),
        .pix_valid_o(pix_valid_o),
        .red_o      (red_o),
        .green_o    (green_o),
        .blue_o     (blue_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .de_o       (de_o),
        .locked_o   (locked_o),
        .sym_err_o  (sym_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pv = -1;
    int se_count = 0;
    int pv_count = 0;
    bit saw_unlock = 1'b0;

    // Reference model state: 7-bit windows kept as integers, absolute boundary cycle.
    int         hw_c, hw0, hw1, hw2;
    int         m_mode;
    int         m_next;
    int         m_good, m_bad;
    int         m_cyc;
    logic       m_pv, m_se, m_lk;
    logic [5:0] m_red, m_green, m_blue;
    logic       m_hs, m_vs, m_de;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] dut_bundle();
        return {pix_valid_o, sym_err_o, locked_o, red_o, green_o, blue_o, hsync_o, vsync_o, de_o};
    endfunction

    function automatic logic [23:0] model_bundle();
        return {m_pv, m_se, m_lk, m_red, m_green, m_blue, m_hs, m_vs, m_de};
    endfunction

    task automatic model_reset();
        hw_c = 0; hw0 = 0; hw1 = 0; hw2 = 0;
        m_mode = 0; m_next = 0; m_good = 0; m_bad = 0; m_cyc = 0;
        m_pv = 1'b0; m_se = 1'b0; m_lk = 1'b0;
        m_red = 6'd0; m_green = 6'd0; m_blue = 6'd0;
        m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0;
    endtask

    // One bit time of the receiver, from the rules: 0=search, 1=verify, 2=locked.
    task automatic model_clock(input logic c, input logic [2:0] l);
        bit match, at_b, emit;
        m_cyc++;
        hw_c = (hw_c * 2 + int'(c)) % 128;
        hw0  = (hw0 * 2 + int'(l[0])) % 128;
        hw1  = (hw1 * 2 + int'(l[1])) % 128;
        hw2  = (hw2 * 2 + int'(l[2])) % 128;
        match = (hw_c == int'(PAT));
        at_b  = (m_cyc == m_next);
        emit  = 1'b0;
        m_pv  = 1'b0;
        m_se  = 1'b0;
        if (m_mode == 0) begin
            if (match) begin
                m_next = m_cyc + 7;
                m_good = 1;
                m_mode = (LOCK == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (at_b) begin
                m_next = m_next + 7;
                if (match) begin
                    m_good++;
                    if (m_good >= LOCK) m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_good = 0;
                end
            end
        end else begin
            if (at_b) begin
                m_next = m_next + 7;
                if (match) begin
                    m_bad = 0;
                    emit  = 1'b1;
                end else begin
                    m_se = 1'b1;
                    m_bad++;
                    if (m_bad >= UNLOCK) begin
                        m_mode = 0;
                        m_bad  = 0;
                        m_good = 0;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
        end
        if (emit) begin
            m_pv    = 1'b1;
            m_red   = 6'(hw0 % 64);
            m_green = 6'((hw1 % 32) * 2 + hw0 / 64);
            m_blue  = 6'((hw2 % 16) * 4 + hw1 / 32);
            m_hs    = ((hw2 / 16) % 2) != 0;
            m_vs    = ((hw2 / 32) % 2) != 0;
            m_de    = (hw2 / 64) != 0;
        end
        m_lk = (m_mode == 2);
    endtask

    task automatic step(input logic c, input logic [2:0] l);
        clk_lane = c;
        lane     = l;
        @(posedge clk);
        #1;
        cyc++;
        model_clock(c, l);
        chk("cycle_outputs", 32'(dut_bundle()), 32'(model_bundle()));
        if (sym_err_o) se_count++;
        if (!locked_o) saw_unlock = 1'b1;
        if (pix_valid_o) begin
            pv_count++;
            if (last_pv >= 0) chk("pv_period", 32'(cyc - last_pv), 32'd7);
            last_pv = cyc;
        end
        if (!locked_o) last_pv = -1;
    endtask

    // Transmit-side word map: px = {R[5:0], G[5:0], B[5:0], HS, VS, DE}; result {w2, w1, w0}.
    function automatic logic [20:0] encode(input logic [20:0] px);
        logic [6:0] w0, w1, w2;
        w0 = {px[9], px[20:15]};
        w1 = {px[4:3], px[14:10]};
        w2 = {px[0], px[1], px[2], px[8:5]};
        return {w2, w1, w0};
    endfunction

    task automatic send_frame(input logic [20:0] px, input logic [6:0] cw, input bit check_pix);
        logic [20:0] ws;
        ws = encode(px);
        for (int i = 6; i >= 0; i--) begin
            step(cw[i], {ws[14 + i], ws[7 + i], ws[i]});
        end
        if (check_pix) begin
            chk("frame_pix_valid", 32'(pix_valid_o), 32'd1);
            chk("frame_pixel", 32'({red_o, green_o, blue_o, hsync_o, vsync_o, de_o}), 32'(px));
        end
    endtask

    task automatic acquire();
        for (int i = 0; i < 5; i++) step(1'b0, 3'($urandom_range(7, 0)));
        for (int f = 0; f < LOCK; f++) begin
            if (f == LOCK - 1) chk("not_locked_early", 32'(locked_o), 32'd0);
            send_frame(21'd0, PAT, 1'b0);
        end
        chk("lock_acquired", 32'(locked_o), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int se0, pv0;
        logic [20:0] px;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(dut_bundle()), 32'd0);
        rst_n = 1'b1;

        acquire();
        for (int f = 0; f < 3; f++) send_frame(21'($urandom), PAT, 1'b1);

        px = {6'h2A, 6'h15, 6'h33, 1'b1, 1'b0, 1'b1};
        send_frame(px, PAT, 1'b1);

        // Alternating glitches never accumulate because each good frame clears the error count.
        se0 = se_count;
        for (int g = 0; g < UNLOCK; g++) begin
            send_frame(21'($urandom), GLITCH, 1'b1);
            chk("glitch_stays_locked", 32'(locked_o), 32'd1);
            send_frame(21'($urandom), PAT, 1'b1);
        end
        chk("glitch_sym_err_count", 32'(se_count - se0), 32'(UNLOCK));

        se0 = se_count;
        saw_unlock = 1'b0;
        step(1'b0, 3'($urandom_range(7, 0)));
        for (int f = 0; f < 7; f++) send_frame(21'($urandom), PAT, 1'b0);
        chk("slip_sym_err_count", 32'(se_count - se0), 32'(UNLOCK));
        chk("slip_saw_unlock", 32'(saw_unlock), 32'd1);
        chk("slip_relocked", 32'(locked_o), 32'd1);
        for (int f = 0; f < 3; f++) send_frame(21'($urandom), PAT, 1'b1);

        // Two-line loopback: 6 active pixels then 2 hsync blanking pixels, vsync on line 0.
        pv0 = pv_count;
        for (int ln = 0; ln < 2; ln++) begin
            for (int p = 0; p < 8; p++) begin
                px = {18'($urandom), (p >= 6), (ln == 0), (p < 6)};
                send_frame(px, PAT, 1'b1);
            end
        end
        chk("loopback_pixel_count", 32'(pv_count - pv0), 32'd16);

        for (int i = 0; i < 3; i++) step(PAT[6 - i], 3'($urandom_range(7, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_outputs", 32'(dut_bundle()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_outputs", 32'(dut_bundle()), 32'd0);
        rst_n = 1'b1;
        last_pv = -1;
        acquire();
        for (int f = 0; f < 2; f++) send_frame(21'($urandom), PAT, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
